// File: rtl/posit_arith_pkg.sv
// posit_arith_pkg
// Shared definitions for the shared leading-zero-count arbiter.
//   - Default operand width, count width and requester count.
//   - lzd_rsp_t: the result record held in the result register. Its fields
//     are sized for the largest supported configuration (8 requesters,
//     operands up to 256 bits); users take the low bits they need.
package posit_arith_pkg;

  localparam int WORD_SIZE_DEFAULT = 32;
  localparam int RS_DEFAULT        = 5;
  localparam int N_REQ_DEFAULT     = 4;

  // Field widths of the stored result, large enough for any legal config.
  localparam int ID_W_MAX  = 3;
  localparam int CNT_W_MAX = 8;

  typedef struct packed {
    logic [ID_W_MAX-1:0]  id;
    logic [CNT_W_MAX-1:0] cnt;
    logic                 zero;
  } lzd_rsp_t;

endpackage

// File: rtl/lzd_share_arb_if.sv
// lzd_share_arb_if
// Bundle of the requester-side and response-side handshake signals.
//   req_valid[N_REQ]      requester -> arbiter  operand valid
//   req_data[N_REQ][W]    requester -> arbiter  operand
//   req_ready[N_REQ]      arbiter -> requester  accept (one-hot or zero)
//   rsp_valid             arbiter -> consumer   result held
//   rsp_ready             consumer -> arbiter   result consumed
//   rsp_id / rsp_cnt / rsp_zero  result owner, leading-zero count, zero flag
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. A source holds valid high and its payload stable until the
// transfer; valid never waits on ready, while ready may depend on valid.
// Result fields are meaningful only while rsp_valid is 1.
interface lzd_share_arb_if
  import posit_arith_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int RS        = RS_DEFAULT,
  parameter int N_REQ     = N_REQ_DEFAULT
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0][WORD_SIZE-1:0] req_data;
  logic [N_REQ-1:0]                req_ready;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [IDW-1:0]                  rsp_id;
  logic [RS-1:0]                   rsp_cnt;
  logic                            rsp_zero;

  // Requesters and result consumer.
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_cnt, rsp_zero
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_cnt, rsp_zero
  );

endinterface

// File: rtl/lzd_count.sv
// lzd_count
// Purely combinational leading-zero counter.
//   data_i  [WORD_SIZE]  operand
//   cnt_o   [RS]         zero bits above the highest set bit (0 when MSB set)
//   zero_o               operand is all zeros (cnt_o is then 0)
module lzd_count
  import posit_arith_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int RS        = RS_DEFAULT
) (
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [RS-1:0]        cnt_o,
  output logic                 zero_o
);

  // Scan from the LSB upward; the last set bit seen is the highest one,
  // so its position overrides every lower hit.
  always_comb begin
    cnt_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (data_i[i]) begin
        cnt_o  = RS'(WORD_SIZE - 1 - i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lzd_share_arb.sv
// lzd_share_arb
// N_REQ requesters share one leading-zero counter through a round-robin
// arbiter. One operand is accepted per cycle into a single result register;
// the result appears the cycle after acceptance.
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   bus      lzd_share_arb_if.slave (requests in, result out)
//   dbg_ptr  current round-robin search start pointer
module lzd_share_arb
  import posit_arith_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int RS        = RS_DEFAULT,
  parameter int N_REQ     = N_REQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lzd_share_arb_if.slave           bus,
  output logic [$clog2(N_REQ)-1:0] dbg_ptr
);

  localparam int IDW = $clog2(N_REQ);

  // State: result register, its valid bit, and the round-robin pointer.
  lzd_rsp_t         rsp_q,       rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;

  logic             slot_free;
  logic             found;
  logic             accept;
  logic [IDW-1:0]   grant_idx;
  logic [N_REQ-1:0] req_ready;
  int               idx;

  logic [WORD_SIZE-1:0] op;
  logic [RS-1:0]        lzd_cnt;
  logic                 lzd_zero;

  // Arbiter: first asserted valid at or after ptr, wrapping around.
  // Ready is suppressed in reset so no accept can happen there.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    accept    = found && slot_free && rst_n;
    req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;
  end

  assign op = bus.req_data[grant_idx];

  lzd_count #(
    .WORD_SIZE (WORD_SIZE),
    .RS        (RS)
  ) u_lzd_count (
    .data_i (op),
    .cnt_o  (lzd_cnt),
    .zero_o (lzd_zero)
  );

  // Next state: an accept always loads (even while draining, so valid stays
  // high); a drain with no accept empties the slot; otherwise hold.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_d.id    = ID_W_MAX'(grant_idx);
      rsp_d.cnt   = CNT_W_MAX'(lzd_cnt);
      rsp_d.zero  = lzd_zero;
      rsp_valid_d = 1'b1;
      ptr_d       = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  // The stored fields are wider than this configuration needs; the upper
  // bits are always zero and intentionally dropped here.
  logic unused_rsp_bits;
  assign unused_rsp_bits = ^rsp_q;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_q.id[IDW-1:0];
  assign bus.rsp_cnt   = rsp_q.cnt[RS-1:0];
  assign bus.rsp_zero  = rsp_q.zero;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_lzd_share_arb.sv
// tb_lzd_share_arb
// Directed bench for lzd_share_arb with the default configuration
// (32-bit operands, 4 requesters). Inputs change 1 time unit after the
// rising edge; outputs are checked 1 more unit later.
module tb_lzd_share_arb;
  import posit_arith_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_ptr;

  int n_checks;
  int n_pass;

  lzd_share_arb_if #(.WORD_SIZE(W), .RS(5), .N_REQ(N)) bus ();

  lzd_share_arb #(.WORD_SIZE(W), .RS(5), .N_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dbg_ptr (dbg_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id,
                           input logic [4:0] cnt, input logic zero);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    check({tag, "_cnt"},   32'(bus.rsp_cnt),   32'(cnt));
    check({tag, "_zero"},  32'(bus.rsp_zero),  32'(zero));
  endtask

  // Single accept from one requester, then one idle cycle to drain.
  task automatic send_one(input string tag, input int id, input logic [31:0] data,
                          input logic [4:0] exp_cnt, input logic exp_zero);
    bus.req_valid     = 4'(1 << id);
    bus.req_data[id]  = data;
    settle();
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << id));
    cyc();
    bus.req_valid = '0;
    settle();
    check_rsp(tag, 2'(id), exp_cnt, exp_zero);
    check({tag, "_ptr"}, 32'(dbg_ptr), 32'((id + 1) % N));
    cyc();
    check({tag, "_drain"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;

    // Reset: ready must stay low even with every requester valid.
    cyc();
    cyc();
    settle();
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_ptr",   32'(dbg_ptr),       32'd0);
    check("rst_id",    32'(bus.rsp_id),    32'd0);
    check("rst_cnt",   32'(bus.rsp_cnt),   32'd0);
    check("rst_zero",  32'(bus.rsp_zero),  32'd0);
    rst_n         = 1'b1;
    bus.req_valid = '0;
    cyc();
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Single requester, then boundary operands. Last send on requester 3
    // wraps the pointer back to 0.
    send_one("single", 2, 32'h0001_0000, 5'd15, 1'b0);
    send_one("msb",    1, 32'h8000_0000, 5'd0,  1'b0);
    send_one("lsb",    0, 32'h0000_0001, 5'd31, 1'b0);
    send_one("zero",   3, 32'h0000_0000, 5'd0,  1'b1);

    // All valid continuously: grants 0,1,2,3,0 with one result per cycle.
    for (int i = 0; i < N; i++) bus.req_data[i] = 32'h8000_0000 >> (4 * i);
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      settle();
      check("rr_ready", 32'(bus.req_ready), 32'(1 << (j % N)));
      cyc();
      check_rsp("rr", 2'(j % N), 5'(4 * (j % N)), 1'b0);
    end

    // Backpressure: result held, no accepts, for three edges.
    bus.rsp_ready = 1'b0;
    settle();
    check("bp_ready0", 32'(bus.req_ready), 32'd0);
    for (int j = 0; j < 3; j++) begin
      cyc();
      check_rsp("bp_hold", 2'd0, 5'd0, 1'b0);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    settle();
    check("bp_release", 32'(bus.req_ready), 32'b0010);
    cyc();
    check_rsp("bp_next", 2'd1, 5'd4, 1'b0);

    // One more accept (requester 2) leaves ptr = 3 with a held result.
    cyc();
    check_rsp("pre_rst", 2'd2, 5'd8, 1'b0);
    check("pre_rst_ptr", 32'(dbg_ptr), 32'd3);

    // Reset pulse while holding a result.
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    settle();
    check("rstp_ready", 32'(bus.req_ready), 32'd0);
    check("rstp_held",  32'(bus.rsp_valid), 32'd1);
    cyc();
    check("rstp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstp_ptr",   32'(dbg_ptr),       32'd0);
    rst_n           = 1'b1;
    bus.rsp_ready   = 1'b1;
    bus.req_valid   = 4'b1010;
    bus.req_data[1] = 32'h0000_0001;
    bus.req_data[3] = 32'h0000_0000;
    settle();
    check("post_rst_ready", 32'(bus.req_ready), 32'b0010);
    cyc();
    check_rsp("post_rst1", 2'd1, 5'd31, 1'b0);
    bus.req_valid = 4'b1000;
    settle();
    check("post_rst_ready3", 32'(bus.req_ready), 32'b1000);
    cyc();
    check_rsp("post_rst3", 2'd3, 5'd0, 1'b1);
    bus.req_valid = '0;
    cyc();
    check("final_drain", 32'(bus.rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lzd_share_arb.md
LZD_SHARE_ARB -- requirements
Module: lzd_share_arb

Interface
REQ-001 Parameter WORD_SIZE, default 32: operand width in bits; power of two, >= 4.
REQ-002 Parameter RS, default 5: count width, $clog2(WORD_SIZE).
REQ-003 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 req_valid  input  N_REQ: per-requester operand valid.
REQ-007 req_data  input  N_REQ x WORD_SIZE: per-requester operand.
REQ-008 req_ready  output  N_REQ: per-requester accept; one-hot or zero.
REQ-009 rsp_valid  output  1: result register holds a result.
REQ-010 rsp_ready  input  1: downstream consumes the result.
REQ-011 rsp_id  output  $clog2(N_REQ): index of the requester that owns the result.
REQ-012 rsp_cnt  output  RS: leading-zero count of the accepted operand, counted from the MSB.
REQ-013 rsp_zero  output  1: accepted operand was all zeros.

Function
REQ-014 Single shared leading-zero counter; at most one operand accepted per cycle.
REQ-015 Accept for requester i = req_valid[i] & req_ready[i].
REQ-016 Slot free = !rsp_valid | rsp_ready.
REQ-017 req_ready[i] = 1 only when the slot is free and i is the round-robin winner among asserted req_valid; otherwise 0.
REQ-018 req_ready may depend combinationally on req_valid and rsp_ready; req_valid must not depend on req_ready.
REQ-019 Round-robin: search starts at pointer ptr and wraps modulo N_REQ; the first asserted req_valid wins.
REQ-020 On accept of requester i, ptr <= (i+1) mod N_REQ; with no accept, ptr holds.
REQ-021 Latency 1 cycle: the operand accepted in cycle t gives rsp_valid=1 with its result in cycle t+1.
REQ-022 Full throughput: back-to-back accepts occur while rsp_ready=1, one result per cycle.
REQ-023 If rsp_valid=1 and rsp_ready=0: rsp_id, rsp_cnt and rsp_zero hold stable, and all req_ready=0.
REQ-024 Simultaneous drain and accept: the result register loads the new result; rsp_valid stays 1.
REQ-025 Drain without accept: rsp_valid <= 0.
REQ-026 rsp_cnt = number of zero bits above the highest set bit (MSB-set gives 0; only LSB set gives WORD_SIZE-1).
REQ-027 All-zero operand: rsp_zero=1, rsp_cnt=0.
REQ-028 When rsp_valid=0, the values of rsp_id, rsp_cnt and rsp_zero are don't-care.
REQ-029 A requester keeps req_valid high and req_data stable until accepted; the block does not store unaccepted operands.

Reset
REQ-030 rst_n=0 at a rising edge: rsp_valid<=0, ptr<=0, rsp_id<=0, rsp_cnt<=0, rsp_zero<=0.
REQ-031 While rst_n=0, all req_ready=0; no accept occurs in a reset cycle.
REQ-032 Reset mid-operation discards any held result without a handshake; the first accept after reset starts the search at requester 0.

Structure
REQ-033 Shared package posit_arith_pkg holds:
- WORD_SIZE and RS defaults
- N_REQ default
- typedef lzd_rsp_t {id, cnt, zero} used for the result register.
REQ-034 One combinational sub-module, lzd_count (WORD_SIZE-bit in -> RS-bit count + zero flag), is instantiated once between arbiter mux and result register.
REQ-035 Arbiter and pointer logic are written inline; there is no FSM beyond rsp_valid and ptr.

Verification
REQ-036 Single requester: req 2 sends 32'h0001_0000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, rsp_cnt=15, rsp_zero=0.
REQ-037 Boundary values:
- 32'h8000_0000 -> cnt=0
- 32'h0000_0001 -> cnt=31
- 32'h0 -> zero=1, cnt=0.
REQ-038 All 4 requesters valid continuously, rsp_ready=1, ptr=0 -> grant order 0,1,2,3,0 with one rsp per cycle.
REQ-039 Backpressure: rsp_ready=0 for 3 cycles with rsp_valid=1 -> outputs stable, req_ready=0; rsp_ready=1 -> the same cycle accepts the next winner.
REQ-040 Reset pulse while rsp_valid=1 and ptr=3 -> next cycle rsp_valid=0; with reqs 1 and 3 valid, req 1 is granted first.
